// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter and transaction sequencer in front of a
// single SPI byte engine. Each requester owns one active-low chip select that is
// held low for its whole multi-byte transaction.
// Optional watchdog in WAIT: define SPI_XFER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | all cs_n high, arbitrate among pending requests
// SETUP | cs_n low, waiting out the chip-select setup time
// START | issue the next byte to the engine once it is not busy
// WAIT  | byte in flight, waiting for spi_done
// HOLD  | last byte done, waiting out the chip-select hold time
// GAP   | cs_n high, enforcing the minimum idle time between transactions
module spi_xfer_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int CS_IDLE_CYC  = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_tx_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     tx_ack,
    output logic [7:0]             rx_data,
    output logic [NUM_REQ-1:0]     rx_valid,
    output logic                   err,
    output logic                   spi_start,
    output logic [7:0]             spi_tx_data,
    input  logic [7:0]             spi_rx_data,
    input  logic                   spi_busy,
    input  logic                   spi_done,
    output logic [NUM_REQ-1:0]     cs_n
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int CMAX = (CS_SETUP_CYC > CS_HOLD_CYC)
                        ? ((CS_SETUP_CYC > CS_IDLE_CYC) ? CS_SETUP_CYC : CS_IDLE_CYC)
                        : ((CS_HOLD_CYC > CS_IDLE_CYC) ? CS_HOLD_CYC : CS_IDLE_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    // Outputs are registered, so each timed phase spends one cycle fewer in its
    // own state; a phase of length 1 is skipped entirely.
    localparam logic [CW-1:0] SETUP_LD = (CS_SETUP_CYC > 1) ? CW'(CS_SETUP_CYC - 2) : '0;
    localparam logic [CW-1:0] HOLD_LD  = (CS_HOLD_CYC > 1)  ? CW'(CS_HOLD_CYC - 2)  : '0;
    localparam logic [CW-1:0] IDLE_LD  = (CS_IDLE_CYC > 1)  ? CW'(CS_IDLE_CYC - 2)  : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_WAIT, S_HOLD, S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_flag_q, last_flag_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
    logic [NUM_REQ-1:0] tx_ack_q, tx_ack_d;
    logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               spi_start_q, spi_start_d;
    logic [7:0]         spi_tx_data_q, spi_tx_data_d;
    logic               found;
    logic [IW-1:0]      win;
    logic               release_cs;

`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        last_flag_d   = last_flag_q;
        gnt_d         = gnt_q;
        cs_n_d        = cs_n_q;
        tx_ack_d      = '0;
        rx_valid_d    = '0;
        rx_data_d     = rx_data_q;
        spi_start_d   = 1'b0;
        spi_tx_data_d = spi_tx_data_q;
        found         = 1'b0;
        win           = '0;
        release_cs    = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
        wd_d          = wd_q;
        err_d         = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
                        found = 1'b1;
                        win   = IW'((int'(ptr_q) + k) % NUM_REQ);
                    end
                end
                if (found) begin
                    ptr_d       = win;
                    idx_d       = win;
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
                    cs_n_d      = '1;
                    cs_n_d[win] = 1'b0;
                    if (CS_SETUP_CYC > 1) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) state_d = S_START;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_START: begin
                if (!spi_busy) begin
                    spi_start_d      = 1'b1;
                    spi_tx_data_d    = req_tx_data[8*idx_q +: 8];
                    tx_ack_d[idx_q]  = 1'b1;
                    last_flag_d      = req_last[idx_q] | ~req[idx_q];
                    state_d          = S_WAIT;
`ifdef SPI_XFER_TIMEOUT_EN
                    wd_d             = '0;
`endif
                end
            end
            S_WAIT: begin
                if (spi_done) begin
                    rx_data_d         = spi_rx_data;
                    rx_valid_d[idx_q] = 1'b1;
                    // A requester that has dropped req by now gets no further bytes.
                    if (last_flag_q || !req[idx_q]) begin
                        if (CS_HOLD_CYC > 1) begin
                            state_d = S_HOLD;
                            cnt_d   = HOLD_LD;
                        end else begin
                            release_cs = 1'b1;
                        end
                    end else begin
                        state_d = S_START;
                    end
                end
`ifdef SPI_XFER_TIMEOUT_EN
                else if (wd_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d      = 1'b1;
                    release_cs = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (cnt_q == '0) release_cs = 1'b1;
                else             cnt_d      = cnt_q - 1'b1;
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (release_cs) begin
            cs_n_d = '1;
            gnt_d  = '0;
            if (CS_IDLE_CYC > 1) begin
                state_d = S_GAP;
                cnt_d   = IDLE_LD;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // State and registered outputs; reset releases every chip select at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= IW'(NUM_REQ - 1);
            idx_q         <= '0;
            cnt_q         <= '0;
            last_flag_q   <= 1'b0;
            gnt_q         <= '0;
            cs_n_q        <= '1;
            tx_ack_q      <= '0;
            rx_valid_q    <= '0;
            rx_data_q     <= 8'h00;
            spi_start_q   <= 1'b0;
            spi_tx_data_q <= 8'h00;
`ifdef SPI_XFER_TIMEOUT_EN
            wd_q          <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            last_flag_q   <= last_flag_d;
            gnt_q         <= gnt_d;
            cs_n_q        <= cs_n_d;
            tx_ack_q      <= tx_ack_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            spi_start_q   <= spi_start_d;
            spi_tx_data_q <= spi_tx_data_d;
`ifdef SPI_XFER_TIMEOUT_EN
            wd_q          <= wd_d;
            err_q         <= err_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign cs_n        = cs_n_q;
    assign tx_ack      = tx_ack_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign spi_start   = spi_start_q;
    assign spi_tx_data = spi_tx_data_q;

endmodule
